// File: rtl/vga_timing_monitor_if.sv
// Bus between a VGA sync/colour source and the timing monitor.
// The master side drives sync and colour and observes the measurement results.
// The slave side (the monitor) receives the stream and publishes the results.
interface vga_timing_monitor_if;
    logic       hsync;
    logic       vsync;
    logic [1:0] red;
    logic [1:0] green;
    logic [1:0] blue;
    logic [9:0] h_total;
    logic [9:0] h_sync_w;
    logic [9:0] v_total;
    logic [9:0] v_sync_w;
    logic       meas_valid;
    logic       locked;
    logic       timing_err;
    logic [5:0] probe_color;
    logic       probe_valid;

    modport master (
        output hsync, vsync, red, green, blue,
        input  h_total, h_sync_w, v_total, v_sync_w,
        input  meas_valid, locked, timing_err, probe_color, probe_valid
    );

    modport slave (
        input  hsync, vsync, red, green, blue,
        output h_total, h_sync_w, v_total, v_sync_w,
        output meas_valid, locked, timing_err, probe_color, probe_valid
    );
endinterface

// File: rtl/vga_timing_monitor.sv
// VGA timing monitor: measures line/frame timing of an incoming hsync/vsync
// stream, declares lock after several matching frames and samples the colour
// at one probe coordinate per frame.
module vga_timing_monitor #(
    parameter int EXP_HTOTAL  = 400,
    parameter int EXP_HSYNC   = 48,
    parameter int EXP_VTOTAL  = 525,
    parameter int EXP_VSYNC   = 2,
    parameter int LOCK_FRAMES = 3,
    parameter int PROBE_X     = 100,
    parameter int PROBE_Y     = 100
) (
    input  logic                 clk12,
    input  logic                 rst_n,
    vga_timing_monitor_if.slave  bus
);
    localparam logic [9:0] LP_HTOTAL  = 10'(EXP_HTOTAL);
    localparam logic [9:0] LP_HSYNC   = 10'(EXP_HSYNC);
    localparam logic [9:0] LP_VTOTAL  = 10'(EXP_VTOTAL);
    localparam logic [9:0] LP_VSYNC   = 10'(EXP_VSYNC);
    localparam logic [3:0] LP_LOCK    = 4'(LOCK_FRAMES);
    localparam logic [9:0] LP_PROBE_X = 10'(PROBE_X);
    localparam logic [9:0] LP_PROBE_Y = 10'(PROBE_Y);
    localparam logic [9:0] LP_MAX     = 10'h3FF;

    typedef enum logic [1:0] {ST_SEARCH, ST_MEASURE, ST_TRACK} state_t;

    state_t     r_state;
    state_t     w_state_next;

    logic       r_hs;
    logic       r_vs;
    logic [9:0] r_x;
    logic [9:0] r_line_period;
    logic [9:0] r_hs_low;
    logic [9:0] r_hsw_latch;
    logic [9:0] r_y;
    logic [9:0] r_vsl;
    logic       r_probe_done;
    logic [3:0] r_match_cnt;
    logic       r_locked;

    logic [9:0] r_h_total;
    logic [9:0] r_h_sync_w;
    logic [9:0] r_v_total;
    logic [9:0] r_v_sync_w;
    logic       r_meas_valid;
    logic       r_timing_err;
    logic [5:0] r_probe_color;
    logic       r_probe_valid;

    logic       w_hs_fall;
    logic       w_hs_rise;
    logic       w_vs_fall;
    logic [9:0] w_x_inc;
    logic [9:0] w_line_now;
    logic [9:0] w_hsw_now;
    logic [9:0] w_vtot_now;
    logic       w_timeout;
    logic       w_match;
    logic       w_probe_hit;
    logic       w_publish;
    logic       w_err;
    logic [3:0] w_match_next;
    logic       w_locked_next;
    logic [3:0] w_match_inc;

    assign w_hs_fall  = r_hs & ~bus.hsync;
    assign w_hs_rise  = ~r_hs & bus.hsync;
    assign w_vs_fall  = r_vs & ~bus.vsync;
    assign w_x_inc    = r_x + 10'd1;
    // A line ending in this very cycle (hsync fall coincident with vsync fall)
    // is the last complete line of the frame being published.
    assign w_line_now = w_hs_fall ? w_x_inc : r_line_period;
    assign w_hsw_now  = w_hs_rise ? r_hs_low : r_hsw_latch;
    // The hsync fall that coincides with vsync fall is not counted in y,
    // so the +1 accounts for that first line of the frame.
    assign w_vtot_now = r_y + 10'd1;
    assign w_timeout  = (r_x == LP_MAX);
    assign w_match    = (w_line_now == LP_HTOTAL) && (w_hsw_now == LP_HSYNC) &&
                        (w_vtot_now == LP_VTOTAL) && (r_vsl == LP_VSYNC);
    assign w_probe_hit = (r_y == LP_PROBE_Y) && (r_x == LP_PROBE_X) && !r_probe_done;
    assign w_match_inc = (r_match_cnt >= LP_LOCK) ? LP_LOCK : (r_match_cnt + 4'd1);

    // Sync edge history and horizontal/vertical measurement counters.
    always_ff @(posedge clk12 or negedge rst_n) begin
        if (!rst_n) begin
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_x           <= '0;
            r_line_period <= '0;
            r_hs_low      <= '0;
            r_hsw_latch   <= '0;
            r_y           <= '0;
            r_vsl         <= '0;
        end else begin
            r_hs <= bus.hsync;
            r_vs <= bus.vsync;
            if (w_hs_fall) begin
                r_x           <= '0;
                r_line_period <= w_x_inc;
            end else if (r_x != LP_MAX) begin
                r_x <= w_x_inc;
            end
            if (w_hs_fall) begin
                r_hs_low <= 10'd1;
            end else if (!bus.hsync && r_hs_low != LP_MAX) begin
                r_hs_low <= r_hs_low + 10'd1;
            end
            if (w_hs_rise) begin
                r_hsw_latch <= r_hs_low;
            end
            // Frame clear wins over a coincident line count.
            if (w_vs_fall) begin
                r_y   <= '0;
                r_vsl <= '0;
            end else if (w_hs_fall) begin
                r_y <= r_y + 10'd1;
                if (!r_vs) begin
                    r_vsl <= r_vsl + 10'd1;
                end
            end
        end
    end

    // Colour probe: one sample per frame at the programmed coordinate.
    always_ff @(posedge clk12 or negedge rst_n) begin
        if (!rst_n) begin
            r_probe_done  <= 1'b0;
            r_probe_color <= '0;
            r_probe_valid <= 1'b0;
        end else begin
            r_probe_valid <= w_probe_hit;
            if (w_probe_hit) begin
                r_probe_color <= {bus.red, bus.green, bus.blue};
            end
            if (w_vs_fall) begin
                r_probe_done <= 1'b0;
            end else if (w_probe_hit) begin
                r_probe_done <= 1'b1;
            end
        end
    end

    // Next-state logic: frame sequencing, comparison and lock accounting.
    always_comb begin
        w_state_next  = r_state;
        w_match_next  = r_match_cnt;
        w_locked_next = r_locked;
        w_publish     = 1'b0;
        w_err         = 1'b0;
        case (r_state)
            ST_SEARCH: begin
                if (w_vs_fall) begin
                    w_state_next  = ST_MEASURE;
                    w_match_next  = '0;
                    w_locked_next = 1'b0;
                end
            end
            ST_MEASURE: begin
                if (w_timeout) begin
                    w_state_next  = ST_SEARCH;
                    w_match_next  = '0;
                    w_locked_next = 1'b0;
                    w_err         = 1'b1;
                end else if (w_vs_fall) begin
                    // First full frame: line data before it may be partial.
                    w_state_next = ST_TRACK;
                    w_publish    = 1'b1;
                end
            end
            ST_TRACK: begin
                if (w_timeout) begin
                    w_state_next  = ST_SEARCH;
                    w_match_next  = '0;
                    w_locked_next = 1'b0;
                    w_err         = 1'b1;
                end else if (w_vs_fall) begin
                    w_publish = 1'b1;
                    if (w_match) begin
                        w_match_next  = w_match_inc;
                        w_locked_next = (w_match_inc == LP_LOCK);
                    end else begin
                        w_match_next  = '0;
                        w_locked_next = 1'b0;
                        w_err         = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = ST_SEARCH;
            end
        endcase
    end

    // State register and registered result outputs.
    always_ff @(posedge clk12 or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_SEARCH;
            r_match_cnt  <= '0;
            r_locked     <= 1'b0;
            r_meas_valid <= 1'b0;
            r_timing_err <= 1'b0;
            r_h_total    <= '0;
            r_h_sync_w   <= '0;
            r_v_total    <= '0;
            r_v_sync_w   <= '0;
        end else begin
            r_state      <= w_state_next;
            r_match_cnt  <= w_match_next;
            r_locked     <= w_locked_next;
            r_meas_valid <= w_publish;
            r_timing_err <= w_err;
            if (w_publish) begin
                r_h_total  <= w_line_now;
                r_h_sync_w <= w_hsw_now;
                r_v_total  <= w_vtot_now;
                r_v_sync_w <= r_vsl;
            end
        end
    end

    assign bus.h_total     = r_h_total;
    assign bus.h_sync_w    = r_h_sync_w;
    assign bus.v_total     = r_v_total;
    assign bus.v_sync_w    = r_v_sync_w;
    assign bus.meas_valid  = r_meas_valid;
    assign bus.locked      = r_locked;
    assign bus.timing_err  = r_timing_err;
    assign bus.probe_color = r_probe_color;
    assign bus.probe_valid = r_probe_valid;
endmodule

// File: tb/tb_vga_timing_monitor.sv
// Testbench for vga_timing_monitor: a reduced-size VGA-like stream with random
// colour and random timing perturbations, an event-timestamp reference model
// feeding expectation queues, and a monitor that checks every output pulse.
module tb_vga_timing_monitor;
    localparam int HT      = 40;
    localparam int HS      = 6;
    localparam int VT      = 30;
    localparam int VS      = 2;
    localparam int LOCK    = 3;
    localparam int PX      = 10;
    localparam int PY      = 12;
    localparam int VS_LINE = 20;

    logic clk12 = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk12 = ~clk12;
    always @(posedge clk12) cyc <= cyc + 1;

    vga_timing_monitor_if vif();

    vga_timing_monitor #(
        .EXP_HTOTAL(HT), .EXP_HSYNC(HS), .EXP_VTOTAL(VT), .EXP_VSYNC(VS),
        .LOCK_FRAMES(LOCK), .PROBE_X(PX), .PROBE_Y(PY)
    ) dut (
        .clk12(clk12),
        .rst_n(rst_n),
        .bus(vif)
    );

    typedef struct { int cyc; int ht; int hw; int vt; int vw; int lk; } pub_t;
    typedef struct { int cyc; int lk; } err_t;
    typedef struct { int cyc; int col; } prb_t;

    pub_t pub_q[$];
    err_t err_q[$];
    prb_t prb_q[$];

    // Reference model state, kept as event timestamps and per-frame tallies.
    int m_hs_p, m_vs_p;
    int m_last_fall;
    int m_line, m_width;
    int m_falls, m_vlow;
    int m_probe_done;
    int m_phase;
    int m_match, m_locked;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 1023) ? 1023 : v;
    endfunction

    task automatic model_reset(input int r);
        m_hs_p = 1; m_vs_p = 1;
        m_last_fall = r - 1;
        m_line = 0; m_width = 0;
        m_falls = 0; m_vlow = 0;
        m_probe_done = 0;
        m_phase = 0; m_match = 0; m_locked = 0;
    endtask

    // One driven cycle k; any resulting output is expected in cycle k+1.
    task automatic model_step(input int k, input logic hs, input logic vs, input logic [5:0] col);
        int x, line_now, width_now, vt_now, vw_now;
        bit fall, rise, vfall, ok;
        x     = sat(k - m_last_fall - 1);
        fall  = (m_hs_p == 1) && !hs;
        rise  = (m_hs_p == 0) && hs;
        vfall = (m_vs_p == 1) && !vs;
        if (x == PX && (m_falls % 1024) == PY && m_probe_done == 0) begin
            prb_q.push_back('{cyc: k + 1, col: int'(col)});
            m_probe_done = 1;
        end
        line_now  = fall ? ((x + 1) % 1024) : m_line;
        width_now = rise ? sat(k - m_last_fall) : m_width;
        vt_now    = (m_falls + 1) % 1024;
        vw_now    = m_vlow % 1024;
        if (m_phase != 0 && x == 1023) begin
            m_phase = 0; m_match = 0; m_locked = 0;
            err_q.push_back('{cyc: k + 1, lk: 0});
        end else if (vfall) begin
            if (m_phase == 0) begin
                m_phase = 1; m_match = 0; m_locked = 0;
            end else begin
                if (m_phase == 2) begin
                    ok = (line_now == HT) && (width_now == HS) && (vt_now == VT) && (vw_now == VS);
                    if (ok) begin
                        m_match  = (m_match + 1 > LOCK) ? LOCK : m_match + 1;
                        m_locked = (m_match == LOCK) ? 1 : 0;
                    end else begin
                        m_match = 0; m_locked = 0;
                        err_q.push_back('{cyc: k + 1, lk: 0});
                    end
                end
                m_phase = 2;
                pub_q.push_back('{cyc: k + 1, ht: line_now, hw: width_now,
                                  vt: vt_now, vw: vw_now, lk: m_locked});
            end
        end
        if (fall) begin
            m_line = line_now;
            m_last_fall = k;
        end
        if (rise) m_width = width_now;
        if (vfall) begin
            m_falls = 0; m_vlow = 0; m_probe_done = 0;
        end else if (fall) begin
            m_falls++;
            if (m_vs_p == 0) m_vlow++;
        end
        m_hs_p = hs;
        m_vs_p = vs;
    endtask

    task automatic tick(input logic hs, input logic vs);
        logic [5:0] col;
        @(posedge clk12);
        #1;
        col = 6'($urandom);
        vif.hsync = hs;
        vif.vsync = vs;
        {vif.red, vif.green, vif.blue} = col;
        model_step(cyc, hs, vs, col);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_h_total"},     int'(vif.h_total), 0);
        chk({tag, "_h_sync_w"},    int'(vif.h_sync_w), 0);
        chk({tag, "_v_total"},     int'(vif.v_total), 0);
        chk({tag, "_v_sync_w"},    int'(vif.v_sync_w), 0);
        chk({tag, "_meas_valid"},  int'(vif.meas_valid), 0);
        chk({tag, "_locked"},      int'(vif.locked), 0);
        chk({tag, "_timing_err"},  int'(vif.timing_err), 0);
        chk({tag, "_probe_color"}, int'(vif.probe_color), 0);
        chk({tag, "_probe_valid"}, int'(vif.probe_valid), 0);
    endtask

    // Release reset just after an edge; the held inputs form the first cycle.
    task automatic release_reset();
        @(posedge clk12);
        #1;
        rst_n = 1'b1;
        model_reset(cyc);
        model_step(cyc, vif.hsync, vif.vsync, {vif.red, vif.green, vif.blue});
    endtask

    task automatic reset_pulse();
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        pub_q.delete();
        err_q.delete();
        prb_q.delete();
        $display("reset pulse at cycle %0d", cyc);
        release_reset();
    endtask

    task automatic drive_line(input int len, input int sw, input logic vs, input int rst_at);
        for (int c = 0; c < len; c++) begin
            tick((c < sw) ? 1'b0 : 1'b1, vs);
            if (c == rst_at) reset_pulse();
        end
    endtask

    // Lines start at the hsync fall; vsync toggles coincident with that fall.
    task automatic drive_frame(input int last_len, input int mid_len, input int sw_last, input int rst_line);
        for (int l = 0; l < VT; l++) begin
            int len, sw;
            logic vs;
            len = (l == VS_LINE - 1) ? last_len : ((l == 5) ? mid_len : HT);
            sw  = (l == VS_LINE - 1) ? sw_last : HS;
            vs  = (l == VS_LINE || l == VS_LINE + 1) ? 1'b0 : 1'b1;
            drive_line(len, sw, vs, (l == rst_line) ? 2 : -1);
        end
    endtask

    task automatic clean_frames(input int n);
        for (int i = 0; i < n; i++) drive_frame(HT, HT, HS, -1);
    endtask

    pub_t mp;
    err_t me;
    prb_t mq;

    // Output monitor: every pulse is matched against the next expectation.
    always @(negedge clk12) begin
        if (rst_n) begin
            if (vif.meas_valid) begin
                if (pub_q.size() == 0) begin
                    chk("meas_valid_unexpected", 1, 0);
                end else begin
                    mp = pub_q.pop_front();
                    $display("publish cyc=%0d h_total=%0d h_sync_w=%0d v_total=%0d v_sync_w=%0d locked=%0d",
                             cyc, vif.h_total, vif.h_sync_w, vif.v_total, vif.v_sync_w, vif.locked);
                    chk("pub_cycle", cyc, mp.cyc);
                    chk("h_total", int'(vif.h_total), mp.ht);
                    chk("h_sync_w", int'(vif.h_sync_w), mp.hw);
                    chk("v_total", int'(vif.v_total), mp.vt);
                    chk("v_sync_w", int'(vif.v_sync_w), mp.vw);
                    chk("locked", int'(vif.locked), mp.lk);
                end
            end else if (pub_q.size() != 0 && pub_q[0].cyc <= cyc) begin
                mp = pub_q.pop_front();
                chk("meas_valid_missing", 0, 1);
            end
            if (vif.timing_err) begin
                if (err_q.size() == 0) begin
                    chk("timing_err_unexpected", 1, 0);
                end else begin
                    me = err_q.pop_front();
                    $display("timing_err cyc=%0d locked=%0d", cyc, vif.locked);
                    chk("err_cycle", cyc, me.cyc);
                    chk("err_locked", int'(vif.locked), me.lk);
                end
            end else if (err_q.size() != 0 && err_q[0].cyc <= cyc) begin
                me = err_q.pop_front();
                chk("timing_err_missing", 0, 1);
            end
            if (vif.probe_valid) begin
                if (prb_q.size() == 0) begin
                    chk("probe_valid_unexpected", 1, 0);
                end else begin
                    mq = prb_q.pop_front();
                    $display("probe cyc=%0d color=%02h", cyc, vif.probe_color);
                    chk("probe_cycle", cyc, mq.cyc);
                    chk("probe_color", int'(vif.probe_color), mq.col);
                end
            end else if (prb_q.size() != 0 && prb_q[0].cyc <= cyc) begin
                mq = prb_q.pop_front();
                chk("probe_valid_missing", 0, 1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind;
        vif.hsync = 1'b1;
        vif.vsync = 1'b1;
        vif.red   = '0;
        vif.green = '0;
        vif.blue  = '0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk12);
        #1;
        check_outputs_zero("reset");
        release_reset();

        // Acquire lock: SEARCH, MEASURE, then three matching frames.
        clean_frames(6);
        chk("locked_after_acquire", int'(vif.locked), m_locked);

        // One line stretched to HT+1 right before vsync, then relock.
        drive_frame(HT + 1, HT, HS, -1);
        clean_frames(4);

        // Random timing perturbations.
        for (int i = 0; i < 8; i++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                1: drive_frame(HT + $urandom_range(1, 3), HT, HS, -1);
                2: drive_frame(HT, HT + $urandom_range(1, 5), HS, -1);
                3: drive_frame(HT, HT, ($urandom_range(0, 1) != 0) ? HS + 1 : HS - 1, -1);
                default: clean_frames(1);
            endcase
        end
        clean_frames(4);
        chk("locked_after_random", int'(vif.locked), m_locked);

        // Hold sync inactive long enough to time out, then restore.
        for (int i = 0; i < 1100; i++) tick(1'b1, 1'b1);
        chk("locked_after_timeout", int'(vif.locked), 0);
        clean_frames(6);
        chk("locked_after_recover", int'(vif.locked), m_locked);

        // Reset asserted for one clock in the middle of a frame.
        drive_frame(HT, HT, HS, 7);
        clean_frames(6);
        chk("locked_after_reset", int'(vif.locked), m_locked);

        for (int i = 0; i < 50 && (pub_q.size() + err_q.size() + prb_q.size()) != 0; i++) begin
            tick(vif.hsync, vif.vsync);
        end
        repeat (2) @(posedge clk12);
        chk("pending_expectations", pub_q.size() + err_q.size() + prb_q.size(), 0);
        chk("locked_final", int'(vif.locked), m_locked);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
